// File: rtl/dvbs2_pkg.sv
// Shared types and constants for the DVB-S2 column byte packer: FSM states,
// per-modulation column counts and the accumulator width formula.
package dvbs2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXTRACT,
        ST_DRAIN
    } state_t;

    // Bits per symbol, i.e. interleaver columns read per bit index.
    localparam int COLS_QPSK   = 2;
    localparam int COLS_8PSK   = 3;
    localparam int COLS_16APSK = 4;
    localparam int COLS_32APSK = 5;

    // One full byte plus the widest symbol, so a push never has to wait for
    // more than one pop.
    function automatic int acc_width(input int out_w, input int num_col);
        return out_w + num_col;
    endfunction

endpackage

// File: rtl/column_bit_gather.sv
// Picks bit idx from each active column word and left-aligns them into one
// symbol, column 0 in the MSB; inactive column positions read as zero.
module column_bit_gather #(
    parameter int NUM_COL = 8,
    parameter int ROW_W   = 45
) (
    input  logic [NUM_COL*ROW_W-1:0]      row,
    input  logic [$clog2(ROW_W)-1:0]      idx,
    input  logic [$clog2(NUM_COL+1)-1:0]  cols,
    output logic [NUM_COL-1:0]            sym
);

    localparam int CW = $clog2(NUM_COL + 1);

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        logic [ROW_W-1:0] word;
        assign word             = row[(NUM_COL-c)*ROW_W-1 -: ROW_W];
        assign sym[NUM_COL-1-c] = (cols > CW'(c)) && word[idx];
    end

endmodule

// File: rtl/dvbs2_column_byte_packer.sv
// Reads an interleaver row out bit-index by bit-index, cfg_cols bits at a time,
// and packs the stream into rotated OUT_W-bit bytes with residue carried across rows.
module dvbs2_column_byte_packer
    import dvbs2_pkg::*;
#(
    parameter int NUM_COL = 8,
    parameter int ROW_W   = 45,
    parameter int OUT_W   = 8
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          fs_en,
    input  logic [$clog2(NUM_COL+1)-1:0]  cfg_cols,
    input  logic [$clog2(OUT_W)-1:0]      cfg_rot,
    input  logic                          row_vld,
    output logic                          row_rdy,
    input  logic [NUM_COL*ROW_W-1:0]      row_data,
    input  logic                          row_last,
    output logic                          byte_vld,
    input  logic                          byte_rdy,
    output logic [OUT_W-1:0]              byte_out,
    output logic                          byte_last,
    output logic                          err_cfg
);

    localparam int CW    = $clog2(NUM_COL + 1);
    localparam int RW    = $clog2(OUT_W);
    localparam int IW    = $clog2(ROW_W);
    localparam int ACC_W = acc_width(OUT_W, NUM_COL);
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);

    state_t                   state_q, state_d;
    logic [NUM_COL*ROW_W-1:0] row_q;
    logic [CW-1:0]            cols_q;
    logic [RW-1:0]            rot_q;
    logic                     last_q;
    logic [IW-1:0]            idx_q;
    logic [ACC_W-1:0]         acc_q, acc_after, acc_push;
    logic [CNT_W-1:0]         cnt_q, cnt_after, cnt_push;
    logic [NUM_COL-1:0]       sym;
    logic [2*OUT_W-1:0]       rot_dbl;
    logic [OUT_W-1:0]         rotated;
    logic accept, cfg_ok, slot_free, full_pop, pad_pop, pop, pop_last, push;

    column_bit_gather #(.NUM_COL(NUM_COL), .ROW_W(ROW_W)) u_gather (
        .row  (row_q),
        .idx  (idx_q),
        .cols (cols_q),
        .sym  (sym)
    );

    assign row_rdy = (state_q == ST_IDLE);
    assign accept  = fs_en && row_vld && row_rdy;
    assign cfg_ok  = (cfg_cols != '0) && (cfg_cols <= CW'(NUM_COL));

    // Accumulator is MSB-aligned with zeros below cnt_q, so the top byte is
    // already LSB-padded when the drain emits a short tail.
    assign rot_dbl = {acc_q[ACC_W-1 -: OUT_W], acc_q[ACC_W-1 -: OUT_W]} << rot_q;
    assign rotated = rot_dbl[2*OUT_W-1 -: OUT_W];

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        slot_free = !byte_vld || byte_rdy;
        full_pop  = (cnt_q >= OUT_CNT) && slot_free;
        pad_pop   = (state_q == ST_DRAIN) && (cnt_q != '0) && (cnt_q < OUT_CNT) && slot_free;
        pop       = full_pop || pad_pop;
        pop_last  = pop && (state_q == ST_DRAIN) && (cnt_q <= OUT_CNT);
        cnt_after = cnt_q;
        acc_after = acc_q;
        if (pop) begin
            cnt_after = full_pop ? cnt_q - OUT_CNT : '0;
            acc_after = acc_q << OUT_W;
        end
        push     = (state_q == ST_EXTRACT) &&
                   (({1'b0, cnt_after} + (CNT_W+1)'(cols_q)) <= (CNT_W+1)'(ACC_W));
        acc_push = acc_after | ({sym, {OUT_W{1'b0}}} >> cnt_after);
        cnt_push = cnt_after + CNT_W'(cols_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept && cfg_ok) state_d = ST_EXTRACT;
            ST_EXTRACT: if (push && idx_q == '0) state_d = last_q ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:   if (cnt_q == '0 || pop_last) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else if (fs_en) state_q <= state_d;
    end

    // NOTE: the row word is wide pure datapath and only read after a legal
    // accept has loaded it, so it carries no reset.
    always_ff @(posedge sys_clk) begin
        if (accept && cfg_ok) row_q <= row_data;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_q    <= '0;
            rot_q     <= '0;
            last_q    <= 1'b0;
            idx_q     <= IW'(ROW_W - 1);
            acc_q     <= '0;
            cnt_q     <= '0;
            byte_vld  <= 1'b0;
            byte_out  <= '0;
            byte_last <= 1'b0;
            err_cfg   <= 1'b0;
        end else if (fs_en) begin
            err_cfg <= accept && !cfg_ok;
            if (accept && cfg_ok) begin
                cols_q <= cfg_cols;
                rot_q  <= cfg_rot;
                last_q <= row_last;
                idx_q  <= IW'(ROW_W - 1);
            end

            if (pop) begin
                byte_out  <= rotated;
                byte_vld  <= 1'b1;
                byte_last <= pop_last;
            end else if (byte_vld && byte_rdy) begin
                byte_vld  <= 1'b0;
                byte_last <= 1'b0;
            end

            if (push) begin
                acc_q <= acc_push;
                cnt_q <= cnt_push;
                idx_q <= (idx_q == '0) ? IW'(ROW_W - 1) : idx_q - IW'(1);
            end else begin
                acc_q <= acc_after;
                cnt_q <= cnt_after;
            end
        end
    end

endmodule

// File: tb/tb_dvbs2_column_byte_packer.sv
// Scoreboard bench: a bit-serial reference model queues expected bytes,
// a negedge monitor pops and compares on every completed byte handshake.
module tb_dvbs2_column_byte_packer;

    localparam int NUM_COL = 8;
    localparam int ROW_W   = 45;
    localparam int OUT_W   = 8;
    localparam int RWID    = NUM_COL * ROW_W;

    logic              sys_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic              fs_en   = 1'b0;
    logic [3:0]        cfg_cols = '0;
    logic [2:0]        cfg_rot  = '0;
    logic              row_vld  = 1'b0;
    logic              row_rdy;
    logic [RWID-1:0]   row_data = '0;
    logic              row_last = 1'b0;
    logic              byte_vld;
    logic              byte_rdy = 1'b0;
    logic [OUT_W-1:0]  byte_out;
    logic              byte_last;
    logic              err_cfg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q[$];
    bit         model_bits[$];

    dvbs2_column_byte_packer #(.NUM_COL(NUM_COL), .ROW_W(ROW_W), .OUT_W(OUT_W)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .fs_en     (fs_en),
        .cfg_cols  (cfg_cols),
        .cfg_rot   (cfg_rot),
        .row_vld   (row_vld),
        .row_rdy   (row_rdy),
        .row_data  (row_data),
        .row_last  (row_last),
        .byte_vld  (byte_vld),
        .byte_rdy  (byte_rdy),
        .byte_out  (byte_out),
        .byte_last (byte_last),
        .err_cfg   (err_cfg)
    );

    always #5 sys_clk = ~sys_clk;

    // Inputs change 1 time unit after posedge; the handshake seen at negedge
    // is the one the next posedge completes.
    always @(negedge sys_clk) begin
        if (rst_n && fs_en && byte_vld && byte_rdy) begin
            logic [8:0] e;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL stream: unexpected byte %02h last=%0b", byte_out, byte_last);
            end else begin
                e = exp_q.pop_front();
                if ({byte_last, byte_out} !== e) begin
                    tests_failed++;
                    $display("FAIL stream: got byte %02h last=%0b, want byte %02h last=%0b",
                             byte_out, byte_last, e[7:0], e[8]);
                end
            end
        end
    end

    function automatic logic [7:0] rotl(input logic [7:0] d, input int k);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[(j + k) % 8] = d[j];
        return r;
    endfunction

    task automatic model_row(input logic [RWID-1:0] d, input int cols);
        logic [RWID-1:0] t;
        for (int idx = ROW_W - 1; idx >= 0; idx--)
            for (int c = 0; c < cols; c++) begin
                t = d >> ((NUM_COL - 1 - c) * ROW_W + idx);
                model_bits.push_back(t[0]);
            end
    endtask

    task automatic model_flush(input int rot);
        logic [7:0] b;
        logic       last;
        while (model_bits.size() > 0) begin
            b = '0;
            for (int j = 7; j >= 0; j--)
                if (model_bits.size() > 0) b[j] = model_bits.pop_front();
            last = (model_bits.size() == 0);
            exp_q.push_back({last, rotl(b, rot)});
        end
    endtask

    task automatic send_row(input logic [RWID-1:0] d, input logic [3:0] cols,
                            input logic [2:0] rot, input logic last);
        bit ok, hs;
        ok = 0;
        row_data = d; cfg_cols = cols; cfg_rot = rot; row_last = last; row_vld = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge sys_clk);
            hs = row_rdy && fs_en;
            @(posedge sys_clk);
            #1;
            if (hs) ok = 1;
        end
        row_vld = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL row_accept: row not accepted within 400 cycles");
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !byte_vld) break;
            @(posedge sys_clk);
            #1;
        end
        tests_run++;
        if (exp_q.size() != 0 || byte_vld) begin
            tests_failed++;
            $display("FAIL drain: %0d bytes still expected after %0d cycles", exp_q.size(), budget);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0b want %0b", name, got, want);
        end
    endtask

    function automatic logic [RWID-1:0] rand_row();
        logic [RWID-1:0] r;
        r = '0;
        for (int i = 0; i < (RWID + 31) / 32; i++) r = (r << 32) | RWID'($urandom());
        return r;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        expect_bit("reset_byte_vld", byte_vld, 1'b0);
        expect_bit("reset_byte_last", byte_last, 1'b0);
        expect_bit("reset_err_cfg", err_cfg, 1'b0);
        expect_bit("reset_row_rdy", row_rdy, 1'b1);
        tests_run++;
        if (byte_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_byte_out: got %02h want 00", byte_out);
        end
        rst_n = 1'b1; fs_en = 1'b1; byte_rdy = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_transpose(input int rot);
        logic [RWID-1:0] d;
        int gaps;
        d = '0;
        for (int k = 0; k < NUM_COL; k++)
            d = d | (RWID'(45'h1 << k) << ((NUM_COL - 1 - k) * ROW_W));
        model_row(d, 8);
        model_flush(rot);
        send_row(d, 4'd8, 3'(rot), 1'b1);
        expect_bit("latency_accept", byte_vld, 1'b0);
        @(posedge sys_clk); #1;
        expect_bit("latency_cycle1", byte_vld, 1'b0);
        @(posedge sys_clk); #1;
        expect_bit("latency_cycle2", byte_vld, 1'b1);
        gaps = 0;
        for (int i = 0; i < 44; i++) begin
            @(posedge sys_clk); #1;
            if (!byte_vld) gaps++;
        end
        tests_run++;
        if (gaps != 0) begin
            tests_failed++;
            $display("FAIL throughput: got %0d idle cycles want 0", gaps);
        end
        wait_drain(100);
    endtask

    task automatic test_cols3_residue();
        for (int r = 0; r < 8; r++) model_row({RWID{1'b1}}, 3);
        model_flush(0);
        for (int r = 0; r < 8; r++) send_row({RWID{1'b1}}, 4'd3, 3'd0, r == 7);
        wait_drain(200);
    endtask

    task automatic test_cols5_pad(input int rot);
        model_row({RWID{1'b1}}, 5);
        model_flush(rot);
        send_row({RWID{1'b1}}, 4'd5, 3'(rot), 1'b1);
        wait_drain(200);
    endtask

    task automatic test_backpressure();
        logic [RWID-1:0] d;
        d = rand_row();
        model_row(d, 8);
        model_flush(2);
        fork
            send_row(d, 4'd8, 3'd2, 1'b1);
            begin
                logic [7:0] held;
                int bad;
                repeat (8) @(posedge sys_clk);
                #1;
                byte_rdy = 1'b0;
                @(negedge sys_clk);
                held = byte_out;
                bad = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge sys_clk);
                    if (byte_out !== held || byte_vld !== 1'b1) bad++;
                    expect_bit("stall_row_rdy", row_rdy, 1'b0);
                end
                tests_run++;
                if (bad != 0) begin
                    tests_failed++;
                    $display("FAIL stall_hold: byte_out moved %0d times, want 0", bad);
                end
                @(posedge sys_clk); #1;
                byte_rdy = 1'b1;
                for (int i = 0; i < 24; i++) begin
                    fs_en = ~fs_en;
                    @(posedge sys_clk); #1;
                end
                fs_en = 1'b1;
            end
        join
        wait_drain(300);
    endtask

    task automatic test_err_cfg();
        int stray;
        send_row({RWID{1'b1}}, 4'd0, 3'd0, 1'b1);
        expect_bit("err_cfg_pulse", err_cfg, 1'b1);
        expect_bit("err_cfg_row_rdy", row_rdy, 1'b1);
        @(posedge sys_clk); #1;
        expect_bit("err_cfg_clear", err_cfg, 1'b0);
        send_row({RWID{1'b1}}, 4'd9, 3'd0, 1'b1);
        expect_bit("err_cfg_over", err_cfg, 1'b1);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk); #1;
            if (byte_vld) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("FAIL err_cfg_no_bytes: got %0d valid cycles want 0", stray);
        end
    endtask

    task automatic test_reset_mid_row();
        logic [RWID-1:0] d;
        model_row({RWID{1'b1}}, 8);
        model_flush(0);
        send_row({RWID{1'b1}}, 4'd8, 3'd0, 1'b1);
        repeat (6) @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        #1;
        expect_bit("midreset_byte_vld", byte_vld, 1'b0);
        expect_bit("midreset_row_rdy", row_rdy, 1'b1);
        exp_q.delete();
        model_bits.delete();
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        d = rand_row();
        model_row(d, 4);
        model_flush(5);
        send_row(d, 4'd4, 3'd5, 1'b1);
        wait_drain(200);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_transpose(0);
        test_transpose(3);
        test_transpose(7);
        test_cols3_residue();
        test_cols5_pad(0);
        test_cols5_pad(1);
        test_backpressure();
        test_err_cfg();
        test_reset_mid_row();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
